imm_ext_arbiter: RTL and testbench

//  Shares one 8->16 immediate-extension datapath between two requesters:
//  req0 is the ALU-immediate path and req1 is the branch-offset path.

---
 rtl/imm_ext_arbiter.sv | 91 +++++++++
 tb/tb_imm_ext_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one IN_W->OUT_W immediate sign/zero-extender between two requesters.
// Optional feature: define IMM_EXT_SHL1_EN to add per-request shift-left-by-one (word-aligned offsets).
module imm_ext_arbiter #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IN_W-1:0]  req0_imm,
  input  logic             req0_unsigned,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IN_W-1:0]  req1_imm,
  input  logic             req1_unsigned,
`ifdef IMM_EXT_SHL1_EN
  input  logic             req0_shl,
  input  logic             req1_shl,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               rr_ptr_q;
  logic [OUT_W-1:0]   data_q;
  logic               id_q;

  logic               any_valid;
  logic               grant_id;
  logic               can_accept;
  logic               transfer;
  logic [IN_W-1:0]    sel_imm;
  logic               sel_unsigned;
  logic [OUT_W-1:0]   ext_data;

  // Grant goes to the lone requester, or to rr_ptr when both are asking.
  always_comb begin
    any_valid    = req0_valid | req1_valid;
    grant_id     = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
    can_accept   = (state_q == EMPTY) | out_ready;
    transfer     = can_accept & any_valid;
    req0_ready   = transfer & ~grant_id;
    req1_ready   = transfer & grant_id;
    sel_imm      = grant_id ? req1_imm : req0_imm;
    sel_unsigned = grant_id ? req1_unsigned : req0_unsigned;
  end

  always_comb begin
    ext_data = {{(OUT_W-IN_W){sel_imm[IN_W-1] & ~sel_unsigned}}, sel_imm};
`ifdef IMM_EXT_SHL1_EN
    if (grant_id ? req1_shl : req0_shl)
      ext_data = {ext_data[OUT_W-2:0], 1'b0};
`endif
  end

  // A new transfer keeps the slot full even while the old result drains.
  always_comb begin
    state_d = state_q;
    if (transfer)
      state_d = FULL;
    else if (out_ready)
      state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= 1'b0;
      data_q   <= '0;
      id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        data_q   <= ext_data;
        id_q     <= grant_id;
        rr_ptr_q <= ~grant_id;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed self-checking bench for imm_ext_arbiter; expected values are hand-computed.
// Shift tests compile only when IMM_EXT_SHL1_EN is defined.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_unsigned;
  logic [7:0]  req0_imm;
  logic        req1_valid, req1_ready, req1_unsigned;
  logic [7:0]  req1_imm;
`ifdef IMM_EXT_SHL1_EN
  logic        req0_shl, req1_shl;
`endif
  logic        out_valid, out_ready, out_id;
  logic [15:0] out_data;

  int checks = 0;
  int fails  = 0;

  imm_ext_arbiter #(.IN_W(8), .OUT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_imm     (req0_imm),
    .req0_unsigned(req0_unsigned),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_imm     (req1_imm),
    .req1_unsigned(req1_unsigned),
`ifdef IMM_EXT_SHL1_EN
    .req0_shl     (req0_shl),
    .req1_shl     (req1_shl),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_id       (out_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req0_imm = 8'h12; req0_unsigned = 1'b1;
    step();
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0)
      begin fails++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000)
      begin fails++; $display("[TB] FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (out_id !== 1'b0)
      begin fails++; $display("[TB] FAIL reset_out_id got=%b exp=0", out_id); end
    req0_valid = 1'b1; req0_imm = 8'h33; req0_unsigned = 1'b0;
    req1_valid = 1'b1; req1_imm = 8'h44; req1_unsigned = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      begin fails++; $display("[TB] FAIL reset_first_grant got=%b%b exp=10", req0_ready, req1_ready); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (out_id !== 1'b0 || out_data !== 16'h0033 || out_valid !== 1'b1)
      begin fails++; $display("[TB] FAIL reset_first_result got=%b/%h/%b exp=0/0033/1", out_id, out_data, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0)
      begin fails++; $display("[TB] FAIL reset_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sign_ext();
    req0_valid = 1'b1; req0_imm = 8'h85; req0_unsigned = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      begin fails++; $display("[TB] FAIL sext_ready got=%b%b exp=10", req0_ready, req1_ready); end
    step();
    req0_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hFF85 || out_id !== 1'b0)
      begin fails++; $display("[TB] FAIL sext_result got=%b/%h/%b exp=1/ff85/0", out_valid, out_data, out_id); end
    step();
  endtask

  task automatic test_zero_ext();
    req1_valid = 1'b1; req1_imm = 8'h85; req1_unsigned = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
      begin fails++; $display("[TB] FAIL zext_ready got=%b%b exp=01", req0_ready, req1_ready); end
    step();
    req1_imm = 8'h7F; req1_unsigned = 1'b0;
    checks++; if (out_data !== 16'h0085 || out_id !== 1'b1)
      begin fails++; $display("[TB] FAIL zext_result got=%h/%b exp=0085/1", out_data, out_id); end
    step();
    req1_valid = 1'b0;
    checks++; if (out_data !== 16'h007F || out_id !== 1'b1 || out_valid !== 1'b1)
      begin fails++; $display("[TB] FAIL sext_positive got=%h/%b/%b exp=007f/1/1", out_data, out_id, out_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_data;
    req0_valid = 1'b1; req0_imm = 8'h01; req0_unsigned = 1'b0;
    req1_valid = 1'b1; req1_imm = 8'h80; req1_unsigned = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req0_ready !== ~i[0] || req1_ready !== i[0])
        begin fails++; $display("[TB] FAIL b2b_grant[%0d] got=%b%b exp=%b%b", i, req0_ready, req1_ready, ~i[0], i[0]); end
      step();
      exp_data = i[0] ? 16'hFF80 : 16'h0001;
      checks++; if (out_valid !== 1'b1 || out_id !== i[0] || out_data !== exp_data)
        begin fails++; $display("[TB] FAIL b2b_result[%0d] got=%b/%b/%h exp=1/%b/%h", i, out_valid, out_id, out_data, i[0], exp_data); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_imm = 8'h7F; req0_unsigned = 1'b1;
    step();
    req0_imm = 8'h10; req0_unsigned = 1'b0;
    req1_valid = 1'b1; req1_imm = 8'hF0; req1_unsigned = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
        begin fails++; $display("[TB] FAIL stall_ready[%0d] got=%b%b exp=00", i, req0_ready, req1_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h007F || out_id !== 1'b0)
        begin fails++; $display("[TB] FAIL stall_hold[%0d] got=%b/%h/%b exp=1/007f/0", i, out_valid, out_data, out_id); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1)
      begin fails++; $display("[TB] FAIL release_grant got=%b%b exp=01", req0_ready, req1_ready); end
    step();
    req1_valid = 1'b0;
    checks++; if (out_data !== 16'h00F0 || out_id !== 1'b1)
      begin fails++; $display("[TB] FAIL release_result got=%h/%b exp=00f0/1", out_data, out_id); end
    step();
    req0_valid = 1'b0;
    checks++; if (out_data !== 16'h0010 || out_id !== 1'b0 || out_valid !== 1'b1)
      begin fails++; $display("[TB] FAIL release_next got=%h/%b/%b exp=0010/0/1", out_data, out_id, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0010)
      begin fails++; $display("[TB] FAIL empty_keep got=%b/%h exp=0/0010", out_valid, out_data); end
  endtask

`ifdef IMM_EXT_SHL1_EN
  task automatic test_shl();
    req1_valid = 1'b1; req1_imm = 8'hFE; req1_unsigned = 1'b0; req1_shl = 1'b1;
    step();
    req1_shl = 1'b0;
    checks++; if (out_data !== 16'hFFFC || out_id !== 1'b1)
      begin fails++; $display("[TB] FAIL shl_on got=%h/%b exp=fffc/1", out_data, out_id); end
    step();
    req1_valid = 1'b0;
    checks++; if (out_data !== 16'hFFFE || out_id !== 1'b1)
      begin fails++; $display("[TB] FAIL shl_off got=%h/%b exp=fffe/1", out_data, out_id); end
    step();
  endtask
`endif

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b0; req0_imm = '0; req0_unsigned = 1'b0;
    req1_valid = 1'b0; req1_imm = '0; req1_unsigned = 1'b0;
`ifdef IMM_EXT_SHL1_EN
    req0_shl = 1'b0; req1_shl = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("[TB] starting directed tests");
    test_reset();
    test_sign_ext();
    test_zero_ext();
    test_back_to_back();
    test_backpressure();
`ifdef IMM_EXT_SHL1_EN
    test_shl();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
